// File: rtl/row_clear_engine.sv
// Line-clear stage: snapshots a settled board, removes full rows one per cycle,
// compacts survivors downward, zero-fills the top and publishes the result.
module row_clear_engine #(
  parameter int ROWS   = 20,
  parameter int COLS   = 10,
  parameter int CELL_W = 4,
  parameter int TOT_W  = 16
) (
  input  logic                                  Clk,
  input  logic                                  Reset,
  input  logic                                  start,
  input  logic [ROWS-1:0][COLS-1:0][CELL_W-1:0] board_in,
  output logic                                  busy,
  output logic                                  done,
  output logic [ROWS-1:0][COLS-1:0][CELL_W-1:0] board_out,
  output logic [$clog2(ROWS+1)-1:0]             lines_cleared,
  output logic [TOT_W-1:0]                      lines_total
);
  localparam int IW = $clog2(ROWS);
  localparam int CW = $clog2(ROWS+1);

  typedef enum logic [1:0] {IDLE, SCAN, FILL, DONE} state_t;

  state_t                                state, state_nxt;
  logic [ROWS-1:0][COLS-1:0][CELL_W-1:0] work, work_nxt;
  logic [IW-1:0]                         rd, wr;
  logic [CW-1:0]                         cnt, cnt_nxt;
  logic                                  row_full;

  function automatic logic [TOT_W-1:0] sat_add(input logic [TOT_W-1:0] a,
                                               input logic [CW-1:0]    b);
    logic [TOT_W:0] s;
    s = {1'b0, a} + (TOT_W+1)'(b);
    if (s[TOT_W]) return '1;
    return s[TOT_W-1:0];
  endfunction

  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (work[rd][c] == '0) row_full = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FILL ends on wr reaching row 0: wr enters FILL at cnt-1, so this is exactly cnt cycles
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = SCAN;
      SCAN: if (rd == '0) state_nxt = (cnt_nxt != '0) ? FILL : DONE;
      FILL: if (wr == '0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_comb begin
    work_nxt = work;
    cnt_nxt  = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          work_nxt = board_in;
          cnt_nxt  = '0;
        end
      end
      SCAN: begin
        if (row_full) cnt_nxt = cnt + CW'(1);
        else          work_nxt[wr] = work[rd];
      end
      FILL: work_nxt[wr] = '0;
      default: ;
    endcase
  end

  // Publish from work_nxt so the row written on the final SCAN/FILL edge is included
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      work          <= '0;
      cnt           <= '0;
      rd            <= '0;
      wr            <= '0;
      board_out     <= '0;
      lines_cleared <= '0;
      lines_total   <= '0;
    end else begin
      work <= work_nxt;
      cnt  <= cnt_nxt;
      if (state == IDLE && start) begin
        rd <= IW'(ROWS-1);
        wr <= IW'(ROWS-1);
      end else begin
        if (state == SCAN && rd != '0) rd <= rd - IW'(1);
        if (((state == SCAN && !row_full) || state == FILL) && wr != '0) wr <= wr - IW'(1);
      end
      if (state_nxt == DONE) begin
        board_out     <= work_nxt;
        lines_cleared <= cnt_nxt;
        lines_total   <= sat_add(lines_total, cnt_nxt);
      end
    end
  end

endmodule
